// File: rtl/cpu_sequencer.sv
// Control sequencer for the 4-bit CPU: a T-state counter plus a combinational
// decode of (tstate, opcode, flags) into the datapath control word.
module cpu_sequencer #(
    parameter int T_MAX = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [7:0] instr,
    input  logic [2:0] flags,
    output logic       pc_en,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_load,
    output logic       ram_en,
    output logic       ram_we,
    output logic       ir_load,
    output logic       ir_en,
    output logic       a_load,
    output logic       a_en,
    output logic       b_load,
    output logic       Ealu,
    output logic [2:0] aluOp,
    output logic       alu_en,
    output logic       flag_load,
    output logic       out_load,
    output logic [2:0] tstate,
    output logic       halted
);
    localparam int TW = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
        OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_STA = 4'h7,
        OP_LDI = 4'h8, OP_JMP = 4'h9, OP_JZ  = 4'hA, OP_JC  = 4'hB,
        OP_OUT = 4'hE, OP_HLT = 4'hF
    } opcode_e;

    typedef struct packed {
        logic       pc_en, pc_inc, pc_load, mar_load, ram_en, ram_we, ir_load, ir_en;
        logic       a_load, a_en, b_load, ealu;
        logic [2:0] alu_op;
        logic       alu_en, flag_load, out_load;
    } ctrl_t;

    logic [TW-1:0] t_q, t_d;
    logic          halted_q, halted_d;
    logic          last;
    logic          gate;
    ctrl_t         raw, ctrl;
    opcode_e       opc;

    // The operand and sign flag are consumed by the datapath, not here.
    logic          unused_inputs;
    assign unused_inputs = ^{instr[3:0], flags[2]};

    assign opc = opcode_e'(instr[7:4]);

    always_comb begin
        raw  = '0;
        last = 1'b0;
        if (t_q == TW'(0)) begin
            raw.pc_en    = 1'b1;
            raw.mar_load = 1'b1;
        end else if (t_q == TW'(1)) begin
            raw.ram_en  = 1'b1;
            raw.ir_load = 1'b1;
            raw.pc_inc  = 1'b1;
        end else begin
            case (opc)
                OP_LDA, OP_STA: begin
                    if (t_q == TW'(2)) begin
                        raw.ir_en    = 1'b1;
                        raw.mar_load = 1'b1;
                    end else begin
                        last = 1'b1;
                        if (opc == OP_LDA) begin
                            raw.ram_en = 1'b1;
                            raw.a_load = 1'b1;
                        end else begin
                            raw.a_en   = 1'b1;
                            raw.ram_we = 1'b1;
                        end
                    end
                end
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                    if (t_q == TW'(2)) begin
                        raw.ir_en    = 1'b1;
                        raw.mar_load = 1'b1;
                    end else if (t_q == TW'(3)) begin
                        raw.ram_en = 1'b1;
                        raw.b_load = 1'b1;
                    end else begin
                        last          = 1'b1;
                        raw.ealu      = 1'b1;
                        raw.alu_op    = 3'(instr[7:4] - 4'h2);
                        raw.alu_en    = 1'b1;
                        raw.a_load    = 1'b1;
                        raw.flag_load = 1'b1;
                    end
                end
                OP_LDI: begin
                    last       = 1'b1;
                    raw.ir_en  = 1'b1;
                    raw.a_load = 1'b1;
                end
                OP_JMP, OP_JZ, OP_JC: begin
                    last        = 1'b1;
                    raw.ir_en   = 1'b1;
                    raw.pc_load = (opc == OP_JMP) ||
                                  (opc == OP_JZ && flags[0]) ||
                                  (opc == OP_JC && flags[1]);
                end
                OP_OUT: begin
                    last         = 1'b1;
                    raw.a_en     = 1'b1;
                    raw.out_load = 1'b1;
                end
                default: last = 1'b1;
            endcase
        end
        if (t_q >= TW'(T_MAX - 1)) begin
            last = 1'b1;
        end
    end

    always_comb begin
        t_d      = t_q;
        halted_d = halted_q;
        if (run && !halted_q) begin
            if (opc == OP_HLT && t_q == TW'(2)) begin
                halted_d = 1'b1;
                t_d      = '0;
            end else if (last) begin
                t_d = '0;
            end else begin
                t_d = t_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q      <= '0;
            halted_q <= 1'b0;
        end else begin
            t_q      <= t_d;
            halted_q <= halted_d;
        end
    end

    // Every strobe is forced low while paused, halted or in reset.
    assign gate = run & ~halted_q & rst_n;
    assign ctrl = gate ? raw : '0;

    assign pc_en     = ctrl.pc_en;
    assign pc_inc    = ctrl.pc_inc;
    assign pc_load   = ctrl.pc_load;
    assign mar_load  = ctrl.mar_load;
    assign ram_en    = ctrl.ram_en;
    assign ram_we    = ctrl.ram_we;
    assign ir_load   = ctrl.ir_load;
    assign ir_en     = ctrl.ir_en;
    assign a_load    = ctrl.a_load;
    assign a_en      = ctrl.a_en;
    assign b_load    = ctrl.b_load;
    assign Ealu      = ctrl.ealu;
    assign aluOp     = ctrl.alu_op;
    assign alu_en    = ctrl.alu_en;
    assign flag_load = ctrl.flag_load;
    assign out_load  = ctrl.out_load;
    assign tstate    = 3'(t_q);
    assign halted    = halted_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Table-driven, scoreboarded bench for cpu_sequencer: one vector per clock.
module tb_cpu_sequencer;
    logic       clk = 1'b0;
    logic       rst_n, run;
    logic [7:0] instr;
    logic [2:0] flags;
    logic       pc_en, pc_inc, pc_load, mar_load, ram_en, ram_we, ir_load, ir_en;
    logic       a_load, a_en, b_load, Ealu, alu_en, flag_load, out_load, halted;
    logic [2:0] aluOp, tstate;

    int n_total = 0;
    int n_pass  = 0;

    cpu_sequencer #(.T_MAX(5)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .flags(flags),
        .pc_en(pc_en), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
        .ram_en(ram_en), .ram_we(ram_we), .ir_load(ir_load), .ir_en(ir_en),
        .a_load(a_load), .a_en(a_en), .b_load(b_load), .Ealu(Ealu), .aluOp(aluOp),
        .alu_en(alu_en), .flag_load(flag_load), .out_load(out_load),
        .tstate(tstate), .halted(halted)
    );

    always #5 clk = ~clk;

    // Strobe word layout: {pc_en,pc_inc,pc_load,mar_load,ram_en,ram_we,ir_load,ir_en,
    //                      a_load,a_en,b_load,Ealu,aluOp[2:0],alu_en,flag_load,out_load}
    localparam logic [17:0] PC_EN = 18'h20000, PC_INC = 18'h10000, PC_LOAD = 18'h08000;
    localparam logic [17:0] MAR_LOAD = 18'h04000, RAM_EN = 18'h02000, RAM_WE = 18'h01000;
    localparam logic [17:0] IR_LOAD = 18'h00800, IR_EN = 18'h00400, A_LOAD = 18'h00200;
    localparam logic [17:0] A_EN = 18'h00100, B_LOAD = 18'h00080, EALU = 18'h00040;
    localparam logic [17:0] ALU_EN = 18'h00004, FLAG_LOAD = 18'h00002, OUT_LOAD = 18'h00001;
    localparam logic [17:0] OP_SUB = 18'h00008, OP_XOR = 18'h00020;
    localparam logic [17:0] FETCH0 = PC_EN | MAR_LOAD;
    localparam logic [17:0] FETCH1 = RAM_EN | IR_LOAD | PC_INC;
    localparam logic [17:0] EXEC4  = EALU | ALU_EN | A_LOAD | FLAG_LOAD;

    typedef struct {
        logic        rst_n, run;
        logic [7:0]  instr;
        logic [2:0]  flags;
        logic [2:0]  t;
        logic [17:0] s;
        logic        h;
    } vec_t;

    typedef struct {
        int          idx;
        logic [2:0]  t;
        logic [17:0] s;
        logic        h;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t v(logic r, logic ru, logic [7:0] i, logic [2:0] f,
                               logic [2:0] t, logic [17:0] s, logic h);
        vec_t x;
        x.rst_n = r; x.run = ru; x.instr = i; x.flags = f;
        x.t = t; x.s = s; x.h = h;
        return x;
    endfunction

    function automatic logic [17:0] strobes();
        return {pc_en, pc_inc, pc_load, mar_load, ram_en, ram_we, ir_load, ir_en,
                a_load, a_en, b_load, Ealu, aluOp, alu_en, flag_load, out_load};
    endfunction

    task automatic compare(string name, exp_t e);
        n_total++;
        if (tstate === e.t && strobes() === e.s && halted === e.h) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got t=%0d s=%05h h=%b, want t=%0d s=%05h h=%b",
                     name, e.idx, tstate, strobes(), halted, e.t, e.s, e.h);
        end
    endtask

    // One vector per cycle: drive after the edge, check on the falling edge.
    task automatic apply(int idx, vec_t x);
        exp_t e;
        rst_n = x.rst_n; run = x.run; instr = x.instr; flags = x.flags;
        e.idx = idx; e.t = x.t; e.s = x.s; e.h = x.h;
        sb.push_back(e);
        @(negedge clk);
        compare("vec", sb.pop_front());
        @(posedge clk);
        #1;
    endtask

    // At most one bus driver in any cycle.
    always @(negedge clk) begin
        n_total++;
        if ($countones({pc_en, ram_en, ir_en, a_en, alu_en}) <= 1) begin
            n_pass++;
        end else begin
            $display("FAIL bus_contention: drivers=%b want at most one",
                     {pc_en, ram_en, ir_en, a_en, alu_en});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0; run = 1'b1; instr = 8'h29; flags = 3'b000;
        // reset, then ADD
        tbl.push_back(v(0, 1, 8'h29, 3'b000, 0, '0, 0));
        tbl.push_back(v(0, 1, 8'h29, 3'b000, 0, '0, 0));
        tbl.push_back(v(1, 1, 8'h29, 3'b000, 0, FETCH0, 0));
        tbl.push_back(v(1, 1, 8'h29, 3'b000, 1, FETCH1, 0));
        tbl.push_back(v(1, 1, 8'h29, 3'b000, 2, IR_EN | MAR_LOAD, 0));
        tbl.push_back(v(1, 1, 8'h29, 3'b000, 3, RAM_EN | B_LOAD, 0));
        tbl.push_back(v(1, 1, 8'h29, 3'b000, 4, EXEC4, 0));
        // SUB
        tbl.push_back(v(1, 1, 8'h35, 3'b000, 0, FETCH0, 0));
        tbl.push_back(v(1, 1, 8'h35, 3'b000, 1, FETCH1, 0));
        tbl.push_back(v(1, 1, 8'h35, 3'b000, 2, IR_EN | MAR_LOAD, 0));
        tbl.push_back(v(1, 1, 8'h35, 3'b000, 3, RAM_EN | B_LOAD, 0));
        tbl.push_back(v(1, 1, 8'h35, 3'b000, 4, EXEC4 | OP_SUB, 0));
        // XOR
        tbl.push_back(v(1, 1, 8'h6A, 3'b000, 0, FETCH0, 0));
        tbl.push_back(v(1, 1, 8'h6A, 3'b000, 1, FETCH1, 0));
        tbl.push_back(v(1, 1, 8'h6A, 3'b000, 2, IR_EN | MAR_LOAD, 0));
        tbl.push_back(v(1, 1, 8'h6A, 3'b000, 3, RAM_EN | B_LOAD, 0));
        tbl.push_back(v(1, 1, 8'h6A, 3'b000, 4, EXEC4 | OP_XOR, 0));
        // JZ taken, then not taken
        tbl.push_back(v(1, 1, 8'hA7, 3'b001, 0, FETCH0, 0));
        tbl.push_back(v(1, 1, 8'hA7, 3'b001, 1, FETCH1, 0));
        tbl.push_back(v(1, 1, 8'hA7, 3'b001, 2, IR_EN | PC_LOAD, 0));
        tbl.push_back(v(1, 1, 8'hA7, 3'b000, 0, FETCH0, 0));
        tbl.push_back(v(1, 1, 8'hA7, 3'b000, 1, FETCH1, 0));
        tbl.push_back(v(1, 1, 8'hA7, 3'b000, 2, IR_EN, 0));
        // STA and OUT
        tbl.push_back(v(1, 1, 8'h7C, 3'b000, 0, FETCH0, 0));
        tbl.push_back(v(1, 1, 8'h7C, 3'b000, 1, FETCH1, 0));
        tbl.push_back(v(1, 1, 8'h7C, 3'b000, 2, IR_EN | MAR_LOAD, 0));
        tbl.push_back(v(1, 1, 8'h7C, 3'b000, 3, A_EN | RAM_WE, 0));
        tbl.push_back(v(1, 1, 8'hE0, 3'b000, 0, FETCH0, 0));
        tbl.push_back(v(1, 1, 8'hE0, 3'b000, 1, FETCH1, 0));
        tbl.push_back(v(1, 1, 8'hE0, 3'b000, 2, A_EN | OUT_LOAD, 0));
        // ADD paused at T3, resumed, then reset at T4
        tbl.push_back(v(1, 1, 8'h29, 3'b000, 0, FETCH0, 0));
        tbl.push_back(v(1, 1, 8'h29, 3'b000, 1, FETCH1, 0));
        tbl.push_back(v(1, 1, 8'h29, 3'b000, 2, IR_EN | MAR_LOAD, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(v(1, 0, 8'h29, 3'b000, 3, '0, 0));
        tbl.push_back(v(1, 1, 8'h29, 3'b000, 3, RAM_EN | B_LOAD, 0));
        tbl.push_back(v(1, 1, 8'h29, 3'b000, 4, EXEC4, 0));
        tbl.push_back(v(0, 1, 8'h29, 3'b000, 0, '0, 0));
        // HLT
        tbl.push_back(v(1, 1, 8'hF0, 3'b000, 0, FETCH0, 0));
        tbl.push_back(v(1, 1, 8'hF0, 3'b000, 1, FETCH1, 0));
        tbl.push_back(v(1, 1, 8'hF0, 3'b000, 2, '0, 0));
        for (int i = 0; i < 10; i++) tbl.push_back(v(1, 1, 8'hF0, 3'b000, 0, '0, 1));
        tbl.push_back(v(0, 1, 8'hF0, 3'b000, 0, '0, 0));
        tbl.push_back(v(1, 1, 8'h00, 3'b000, 0, FETCH0, 0));
        tbl.push_back(v(1, 1, 8'h00, 3'b000, 1, FETCH1, 0));
        tbl.push_back(v(1, 1, 8'h00, 3'b000, 2, '0, 0));
        tbl.push_back(v(1, 1, 8'h00, 3'b000, 0, FETCH0, 0));

        for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

        // Asynchronous reset between clock edges, mid-instruction at T2.
        apply(100, v(1, 1, 8'h29, 3'b000, 1, FETCH1, 0));
        #2 rst_n = 1'b0;
        #1;
        e.idx = 101; e.t = 0; e.s = '0; e.h = 0;
        compare("async_rst", e);
        @(posedge clk);
        #1;
        // Run held low out of reset: counter stays at T0 with no strobes.
        for (int i = 0; i < 3; i++) apply(110 + i, v(1, 0, 8'h29, 3'b000, 0, '0, 0));
        apply(120, v(1, 1, 8'h29, 3'b000, 0, FETCH0, 0));
        apply(121, v(1, 1, 8'h29, 3'b000, 1, FETCH1, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
